trace_uart: RTL and testbench
=============================

# trace_uart

Parametrised hardware trace port for the Hack computer. Watches the CPU debug bus (PC, instruction, data-memory write), queues selected events in a small FIFO, and streams them as ASCII hex lines over an 8N1 UART on `txp`. Instantiated in `top` beside `computer`, replacing ad-hoc print logic with a non-blocking, loss-counting tracer.

## Interface
- `CLK_FREQ`, 27_000_000: clock frequency in Hz.
- `BAUD`, 115_200: UART bit rate; `DIV = (CLK_FREQ + BAUD/2) / BAUD` clocks per bit, must be ≥ 2.
- `FIFO_DEPTH`, 16: event FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mode`  in  2  capture select: 0 off, 1 PC changes, 2 memory writes, 3 both.
- `trace_pc`  in  16  current PC.
- `trace_addr`  in  16  data-memory address.
- `trace_data`  in  16  data-memory write data.
- `trace_we`  in  1  data-memory write strobe, one per clk.
- `txp`  out  1  UART TX line, idle high.
- `busy`  out  1  high while a record is being serialised or FIFO is non-empty.
- `overflow`  out  1  sticky; set on any dropped event.
- `dropped_cnt`  out  8  dropped events, saturating at 255.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Reset values: `txp`=1, `busy`=0, `overflow`=0, `dropped_cnt`=0, `fifo_level`=0; FIFO empty; `last_pc`=16'hFFFF; formatter/UART idle.
- Event detection, each cycle: `p_ev` = mode[0] & (`trace_pc` != `last_pc`); `w_ev` = mode[1] & `trace_we`. `last_pc` <= `trace_pc` every cycle regardless of mode.
- If `p_ev|w_ev`: push one entry {p_ev, w_ev, trace_pc, trace_addr, trace_data}. Simultaneous P and W share one entry.
- FIFO full on push: entry dropped; `overflow` <= 1; `dropped_cnt` += 1 unless 255. Push and pop in the same cycle on a full FIFO succeed (level unchanged).
- Formatter pops one entry when idle and FIFO non-empty; emits:
  - if p: 'P', 4 hex digits of pc, CR, LF (7 bytes);
  - then if w: 'W', 4 hex of addr, '=', 4 hex of data, CR, LF (12 bytes).
- Hex digits MSB nibble first, uppercase: 0-9 → 8'h30-39, A-F → 8'h41-46.
- UART: start bit 0, 8 data bits LSB first, stop bit 1; each bit exactly DIV clocks.
- FSM: IDLE → LOAD (pop, latch entry) → SEND (byte index 0..n-1, wait UART done) → IDLE. After P line, continues into W line without returning to IDLE.
- `mode` changes affect capture only; queued and in-flight records always complete.
- `overflow`/`dropped_cnt` clear only on reset.

## Timing
- Event in cycle N → entry visible in `fifo_level` at cycle N+1.
- FIFO empty and formatter idle: `txp` falls (start bit) at cycle N+3 (N+1 pop, N+2 load byte, N+3 start).
- Bytes within a record are back-to-back: next start bit immediately follows previous stop bit's DIV cycles.
- Gap between records ≤ 2 idle clocks of `txp`=1.
- Record duration: P = 70·DIV clocks, W = 120·DIV clocks, both = 190·DIV (plus gap rules).
- `busy` asserts cycle N+1 after first push, deasserts the cycle after the last stop bit completes with FIFO empty.
- Reset asserted mid-frame: `txp` to 1 immediately (asynchronous), FIFO flushed, partial byte abandoned; no output until a new event after release.
- First cycle after reset release with mode[0]=1 and any `trace_pc` != FFFF produces a P event.

## Test plan
- CLK_FREQ=1_000_000, BAUD=250_000 (DIV=4), mode=1, PC 0x0000→0x0001→0x0001: exactly two lines "P0000\r\n", "P0001\r\n"; first start bit at cycle N+3; each bit 4 clocks.
- mode=2, `trace_we`=1 one cycle with addr=0x6000, data=0x002A: "W6000=002A\r\n" only; PC changes ignored.
- mode=3, PC change and write in same cycle (pc=0x00AB, addr=0x0010, data=0xBEEF): single entry, output "P00AB\r\n" then "W0010=BEEF\r\n".
- FIFO_DEPTH=4, mode=1, PC increments every cycle for 300 cycles: `fifo_level` never exceeds 4, `overflow`=1, `dropped_cnt`=255 saturated; decoded lines strictly increasing PC, no corrupted bytes.
- Reset pulse (low 2 cycles) mid-data-bit of a byte: `txp`=1 asynchronously, `fifo_level`=0, `dropped_cnt`=0, `busy`=0; next event produces a clean complete line.
- mode switched 3→0 during a W line: line completes fully; no further entries pushed.

Source files
------------

// File: rtl/trace_uart.sv
// trace_uart: watches the Hack CPU debug bus, queues PC-change and
// data-memory-write events in a small FIFO and streams each one as an ASCII
// hex line ("Pxxxx\r\n", "Waaaa=dddd\r\n") over an 8N1 UART on txp.
// Events that arrive while the FIFO is full are dropped and counted; the CPU
// is never stalled.
//
// Formatter FSM
//   state  | meaning
//   S_IDLE | no record latched; pops the FIFO head when one is available
//   S_LOAD | record latched, first byte waiting for the UART
//   S_SEND | handing the remaining bytes of the record to the UART
module trace_uart #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    mode,
  input  logic [15:0]                   trace_pc,
  input  logic [15:0]                   trace_addr,
  input  logic [15:0]                   trace_data,
  input  logic                          trace_we,
  output logic                          txp,
  output logic                          busy,
  output logic                          overflow,
  output logic [7:0]                    dropped_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int EW  = 50;

  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_t;

  // ---------------------------------------------------------------------
  // Event detection
  // ---------------------------------------------------------------------
  logic [15:0] last_pc;
  logic        p_ev;
  logic        w_ev;
  logic        ev;

  assign p_ev = mode[0] & (trace_pc != last_pc);
  assign w_ev = mode[1] & trace_we;
  assign ev   = p_ev | w_ev;

  // Previous PC tracked unconditionally so enabling PC capture later does
  // not fire on a stale comparison.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_pc <= 16'hFFFF;
    end else begin
      last_pc <= trace_pc;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] head;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  // A full FIFO still accepts a push in the cycle the formatter pops.
  assign push  = ev & (~full | pop);
  assign drop  = ev & full & ~pop;
  assign head  = mem[rd_ptr];

  // Entry storage; contents are only meaningful between the pointers, so
  // no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {p_ev, w_ev, trace_pc, trace_addr, trace_data};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Loss accounting: sticky flag plus saturating counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow    <= 1'b0;
      dropped_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropped_cnt != 8'hFF) begin
        dropped_cnt <= dropped_cnt + 8'd1;
      end
    end
  end

  assign fifo_level = level;

  // ---------------------------------------------------------------------
  // UART transmitter
  // ---------------------------------------------------------------------
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic [3:0]    tx_bits;
  logic [CW-1:0] tx_cnt;
  logic [8:0]    tx_shift;
  logic          tx_last;
  logic          tx_ready;

  // tx_last marks the final clock of the stop bit; accepting a new byte
  // there makes bytes within a record back-to-back.
  assign tx_last  = tx_active & (tx_cnt == '0) & (tx_bits == 4'd0);
  assign tx_ready = ~tx_active | tx_last;

  // Bit serialiser: start bit, 8 data bits LSB first, stop bit, DIV clocks each.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txp       <= 1'b1;
      tx_active <= 1'b0;
      tx_bits   <= 4'd0;
      tx_cnt    <= '0;
      tx_shift  <= '0;
    end else if (tx_start) begin
      txp       <= 1'b0;
      tx_shift  <= {1'b1, tx_byte};
      tx_bits   <= 4'd9;
      tx_cnt    <= DIV_M1;
      tx_active <= 1'b1;
    end else if (tx_active) begin
      if (tx_cnt == '0) begin
        if (tx_bits == 4'd0) begin
          tx_active <= 1'b0;
          txp       <= 1'b1;
        end else begin
          txp      <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[8:1]};
          tx_bits  <= tx_bits - 4'd1;
          tx_cnt   <= DIV_M1;
        end
      end else begin
        tx_cnt <= tx_cnt - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Record formatter
  // ---------------------------------------------------------------------
  state_t      state;
  state_t      state_nx;
  logic [4:0]  idx;
  logic [4:0]  idx_nx;
  logic        rec_p;
  logic        rec_w;
  logic [15:0] rec_pc;
  logic [15:0] rec_addr;
  logic [15:0] rec_data;
  logic [4:0]  rec_len;
  logic [4:0]  pos;
  logic        in_w;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign rec_len = (rec_p ? 5'd7 : 5'd0) + (rec_w ? 5'd12 : 5'd0);

  // State, byte index and latched record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= 5'd0;
      rec_p    <= 1'b0;
      rec_w    <= 1'b0;
      rec_pc   <= 16'd0;
      rec_addr <= 16'd0;
      rec_data <= 16'd0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (pop) begin
        {rec_p, rec_w, rec_pc, rec_addr, rec_data} <= head;
      end
    end
  end

  // Next state: pop when idle, then feed one byte per UART slot; the P line
  // runs straight into the W line because both share one byte index.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    pop      = 1'b0;
    tx_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          idx_nx   = 5'd0;
          state_nx = S_LOAD;
        end
      end
      S_LOAD, S_SEND: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          if (idx == rec_len - 5'd1) begin
            idx_nx   = 5'd0;
            state_nx = S_IDLE;
          end else begin
            idx_nx   = idx + 5'd1;
            state_nx = S_SEND;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Map the byte index to a position within the P or W line.
  always_comb begin
    in_w = 1'b1;
    pos  = idx;
    if (rec_p && (idx < 5'd7)) begin
      in_w = 1'b0;
    end else if (rec_p) begin
      pos = idx - 5'd7;
    end
  end

  // Character generator for the current byte.
  always_comb begin
    tx_byte = 8'h0A;
    if (!in_w) begin
      case (pos)
        5'd0:    tx_byte = 8'h50;
        5'd1:    tx_byte = hex_char(rec_pc[15:12]);
        5'd2:    tx_byte = hex_char(rec_pc[11:8]);
        5'd3:    tx_byte = hex_char(rec_pc[7:4]);
        5'd4:    tx_byte = hex_char(rec_pc[3:0]);
        5'd5:    tx_byte = 8'h0D;
        default: tx_byte = 8'h0A;
      endcase
    end else begin
      case (pos)
        5'd0:    tx_byte = 8'h57;
        5'd1:    tx_byte = hex_char(rec_addr[15:12]);
        5'd2:    tx_byte = hex_char(rec_addr[11:8]);
        5'd3:    tx_byte = hex_char(rec_addr[7:4]);
        5'd4:    tx_byte = hex_char(rec_addr[3:0]);
        5'd5:    tx_byte = 8'h3D;
        5'd6:    tx_byte = hex_char(rec_data[15:12]);
        5'd7:    tx_byte = hex_char(rec_data[11:8]);
        5'd8:    tx_byte = hex_char(rec_data[7:4]);
        5'd9:    tx_byte = hex_char(rec_data[3:0]);
        5'd10:   tx_byte = 8'h0D;
        default: tx_byte = 8'h0A;
      endcase
    end
  end

  assign busy = ~empty | (state != S_IDLE) | tx_active;

endmodule

// File: tb/tb_trace_uart.sv
// Bench for trace_uart at DIV=4, FIFO_DEPTH=4. Expected ASCII bytes are
// queued when an event is driven and popped by a UART line decoder.
module tb_trace_uart;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] pc;
  logic [15:0] addr;
  logic [15:0] data;
  logic        we;
  logic        txp;
  logic        busy;
  logic        overflow;
  logic [7:0]  dropped_cnt;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  bit         sb_on = 1'b1;
  string      hx = "0123456789ABCDEF";

  trace_uart #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (250_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .mode       (mode),
    .trace_pc   (pc),
    .trace_addr (addr),
    .trace_data (data),
    .trace_we   (we),
    .txp        (txp),
    .busy       (busy),
    .overflow   (overflow),
    .dropped_cnt(dropped_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hex4(input logic [15:0] v);
    for (int i = 0; i < 4; i++) exp_q.push_back(hx[v[15-4*i -: 4]]);
  endtask

  task automatic push_p(input logic [15:0] v);
    exp_q.push_back("P");
    push_hex4(v);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_w(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back("W");
    push_hex4(a);
    exp_q.push_back("=");
    push_hex4(d);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  function automatic logic [4:0] unhex(input logic [7:0] c);
    unhex = 5'h10;
    for (int i = 0; i < 16; i++) if (hx[i] == c) unhex = 5'(i);
  endfunction

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (txp !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("start_seen", txp, 0);
  endtask

  // UART decoder: samples every negedge, checks each bit is stable for DIV
  // clocks, takes the value mid-bit, and compares each byte with the queue.
  initial begin
    int         phase;
    logic [9:0] bits;
    logic       cur;
    logic       glitch;
    logic [8:0] want;
    phase  = -1;
    bits   = '0;
    cur    = 1'b1;
    glitch = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        phase = -1;
      end else begin
        if (phase < 0 && txp === 1'b0) begin
          phase  = 0;
          glitch = 1'b0;
        end
        if (phase >= 0) begin
          if (phase % DIV == 0) cur = txp;
          else if (txp !== cur) glitch = 1'b1;
          if (phase % DIV == DIV / 2) bits[phase / DIV] = txp;
          if (phase == 10 * DIV - 1) begin
            check("rx_frame", {glitch, bits[0], bits[9]}, 3'b001);
            if (sb_on) begin
              want = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
              check("rx_byte", {1'b0, bits[8:1]}, want);
            end else begin
              rx_q.push_back(bits[8:1]);
            end
            phase = -1;
          end else begin
            phase++;
          end
        end
      end
    end
  end

  initial begin
    int         n;
    int         maxlvl;
    int         prev;
    logic [4:0] nib;
    logic [16:0] val;
    logic       ok;
    logic       all_high;

    // ---- reset state, first P event timing ----
    rst_n = 1'b0;
    mode  = 2'd1;
    pc    = 16'h0000;
    addr  = 16'h0000;
    data  = 16'h0000;
    we    = 1'b0;
    repeat (3) tick();
    check("rst_txp", txp, 1);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dropped", dropped_cnt, 0);
    check("rst_level", fifo_level, 0);
    push_p(16'h0000);
    push_p(16'h0001);
    rst_n = 1'b1;
    tick();
    check("p_level_n1", fifo_level, 1);
    check("p_busy_n1", busy, 1);
    tick();
    check("p_txp_n2", txp, 1);
    check("p_level_n2", fifo_level, 0);
    tick();
    check("p_start_n3", txp, 0);
    pc = 16'h0001;
    tick();
    pc = 16'h0001;
    wait_idle(3000, n);
    check("p_queue_drained", exp_q.size(), 0);

    // ---- mode 2: single write, PC changes ignored ----
    mode = 2'd2;
    pc = 16'h0005;
    tick();
    pc = 16'h0006;
    tick();
    check("w_pc_ignored", fifo_level, 0);
    push_w(16'h6000, 16'h002A);
    pc   = 16'h0007;
    addr = 16'h6000;
    data = 16'h002A;
    we   = 1'b1;
    tick();
    we = 1'b0;
    check("w_level_n1", fifo_level, 1);
    tick();
    tick();
    check("w_start_n3", txp, 0);
    wait_idle(2000, n);
    check("w_duration", n, 120 * DIV);
    check("w_queue_drained", exp_q.size(), 0);

    // ---- mode 3: simultaneous P and W share one entry ----
    mode = 2'd3;
    push_p(16'h00AB);
    push_w(16'h0010, 16'hBEEF);
    pc   = 16'h00AB;
    addr = 16'h0010;
    data = 16'hBEEF;
    we   = 1'b1;
    tick();
    we = 1'b0;
    check("pw_single_entry", fifo_level, 1);
    tick();
    tick();
    check("pw_start_n3", txp, 0);
    wait_idle(3000, n);
    check("pw_duration", n, 190 * DIV);
    check("pw_queue_drained", exp_q.size(), 0);

    // ---- overflow: PC changes every cycle for 300 cycles ----
    check("pre_ovf_dropped", dropped_cnt, 0);
    sb_on = 1'b0;
    rx_q.delete();
    mode = 2'd1;
    maxlvl = 0;
    for (int i = 0; i < 300; i++) begin
      pc = 16'h0100 + 16'(i);
      tick();
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    end
    wait_idle(6000, n);
    sb_on = 1'b0;
    check("ovf_max_level", maxlvl, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_dropped_sat", dropped_cnt, 255);
    check("ovf_rx_mod7", rx_q.size() % 7, 0);
    check("ovf_rx_lines", rx_q.size() >= 14, 1);
    prev = -1;
    for (int i = 0; i + 7 <= rx_q.size(); i += 7) begin
      ok  = (rx_q[i] == 8'h50) && (rx_q[i+5] == 8'h0D) && (rx_q[i+6] == 8'h0A);
      val = '0;
      for (int k = 1; k <= 4; k++) begin
        nib = unhex(rx_q[i+k]);
        if (nib[4]) ok = 1'b0;
        val = {val[12:0], nib[3:0]};
      end
      check("ovf_line_fmt", ok, 1);
      if (i == 0) check("ovf_first_pc", val, 16'h0100);
      check("ovf_pc_increasing", int'(val) > prev, 1);
      prev = int'(val);
    end
    sb_on = 1'b1;

    // ---- reset mid data bit ----
    pc = 16'h0300;
    tick();
    pc = 16'h0301;
    tick();
    pc = 16'h0302;
    tick();
    wait_start(20);
    repeat (14) tick();
    check("rst_mid_txp_low", txp, 0);
    check("rst_mid_level_before", fifo_level, 2);
    #1;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("rst_mid_txp_async", txp, 1);
    check("rst_mid_level", fifo_level, 0);
    check("rst_mid_dropped", dropped_cnt, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_overflow", overflow, 0);
    mode = 2'd0;
    tick();
    tick();
    rst_n = 1'b1;
    all_high = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (txp !== 1'b1 || fifo_level !== 3'd0) all_high = 1'b0;
    end
    check("rst_mid_quiet", all_high, 1);
    mode = 2'd2;
    push_w(16'h1234, 16'hABCD);
    addr = 16'h1234;
    data = 16'hABCD;
    we   = 1'b1;
    tick();
    we = 1'b0;
    wait_idle(2000, n);
    check("rst_mid_clean_line", exp_q.size(), 0);

    // ---- mode 3 -> 0 during W line ----
    mode = 2'd3;
    push_p(16'h0200);
    push_w(16'h0020, 16'h1357);
    pc   = 16'h0200;
    addr = 16'h0020;
    data = 16'h1357;
    we   = 1'b1;
    tick();
    we = 1'b0;
    check("m30_level", fifo_level, 1);
    wait_start(10);
    repeat (85 * DIV) tick();
    check("m30_busy_in_w", busy, 1);
    mode = 2'd0;
    maxlvl = 0;
    for (int i = 0; i < 20; i++) begin
      pc = 16'h0400 + 16'(i);
      we = 1'b1;
      tick();
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    end
    we = 1'b0;
    check("m30_no_push", maxlvl, 0);
    wait_idle(3000, n);
    check("m30_line_complete", exp_q.size(), 0);
    check("m30_dropped", dropped_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
